// File: rtl/led_mode_controller_if.sv
// Button/LED bundle for led_mode_controller.
// The master drives the raw buttons and observes the LED, mode and press
// outputs. The slave is the controller.
interface led_mode_controller_if;
    logic [2:0] button_n;
    logic       led;
    logic [1:0] mode;
    logic [2:0] press_event;

    modport master (output button_n, input led, mode, press_event);
    modport slave  (input button_n, output led, mode, press_event);
endinterface

// File: rtl/led_mode_controller.sv
// led_mode_controller: three inverting push buttons drive one LED.
// Each button is synchronized, debounced and edge-detected. The per-cycle
// press is picked by fixed priority (0 > 1 > 2) and steps the LED through
// OFF / ON / BLINK_SLOW / BLINK_FAST.
// Optional feature: define LED_MODE_CONTROLLER_AUTO_OFF_EN to return to OFF
// after AUTO_OFF_CYCLES without an accepted press.
module led_mode_controller #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int SLOW_HALF_PERIOD = 25000000,
    parameter int FAST_HALF_PERIOD = 5000000,
    parameter int AUTO_OFF_CYCLES  = 1500000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    led_mode_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_ON   = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_FAST = 2'b11
    } mode_t;

    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int BLINK_MAX = (SLOW_HALF_PERIOD > FAST_HALF_PERIOD) ? SLOW_HALF_PERIOD : FAST_HALF_PERIOD;
    localparam int BLINK_W   = $clog2(BLINK_MAX);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF_PERIOD - 1);
    localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF_PERIOD - 1);

    // Parameters below 2 would give zero-width counters.
    if (DEBOUNCE_CYCLES < 2 || SLOW_HALF_PERIOD < 2 || FAST_HALF_PERIOD < 2 || AUTO_OFF_CYCLES < 2) begin : g_param_check
        $error("led_mode_controller: all cycle parameters must be >= 2");
    end

    logic [2:0]       sync_1, sync_2;
    logic [1:0]       warm;
    logic [2:0]       stable, stable_d, armed;
    logic [DEB_W-1:0] deb_cnt [3];
    logic [2:0]       raw_press, accept;
    logic             timeout;
    mode_t            mode_q, mode_d;
    logic [2:0]       press_event_q;
    logic             led_q;
    logic [BLINK_W-1:0] blink_cnt;

    // Two-flop synchronizer, plus a warm-up flag that marks when sync_2 shows real input.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            sync_1 <= '1;
            sync_2 <= '1;
            warm   <= '0;
        end else begin
            sync_1 <= bus.button_n;
            sync_2 <= sync_1;
            warm   <= {warm[0], 1'b1};
        end
    end

    // Per-button debounce. A button is armed only after it is seen released,
    // so a button held through reset cannot fire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= '1;
            stable_d <= '1;
            armed    <= '0;
            // NOTE: the counter array is plain flops, so it is cleared like any other register.
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (warm[1] && sync_2[i]) armed[i] <= 1'b1;
                if (sync_2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync_2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign raw_press = stable_d & ~stable & armed;

    // Fixed-priority pick of one press per cycle. Lower-priority presses are dropped.
    always_comb begin
        // NOTE: defaults first keep this block free of inferred latches.
        accept = 3'b000;
        if (raw_press[0])      accept = 3'b001;
        else if (raw_press[1]) accept = 3'b010;
        else if (raw_press[2]) accept = 3'b100;
    end

`ifdef LED_MODE_CONTROLLER_AUTO_OFF_EN
    localparam int AUTO_W = $clog2(AUTO_OFF_CYCLES);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_OFF_CYCLES - 1);
    logic [AUTO_W-1:0] idle_cnt;

    // Inactivity timer: cleared by a press or by entering OFF, runs while lit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (accept != 3'b000 || (mode_d == MODE_OFF && mode_q != MODE_OFF))
            idle_cnt <= '0;
        else if (mode_q != MODE_OFF)
            idle_cnt <= idle_cnt + AUTO_W'(1);
    end

    assign timeout = (mode_q != MODE_OFF) && (idle_cnt == AUTO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic. An accepted press takes precedence over the timeout.
    always_comb begin
        mode_d = mode_q;
        case (accept)
            3'b001: mode_d = (mode_q == MODE_OFF) ? MODE_ON : MODE_OFF;
            3'b010: begin
                case (mode_q)
                    MODE_ON:   mode_d = MODE_SLOW;
                    MODE_SLOW: mode_d = MODE_FAST;
                    MODE_FAST: mode_d = MODE_ON;
                    default:   mode_d = mode_q;
                endcase
            end
            3'b100: begin
                case (mode_q)
                    MODE_ON:   mode_d = MODE_FAST;
                    MODE_SLOW: mode_d = MODE_FAST;
                    MODE_FAST: mode_d = MODE_SLOW;
                    default:   mode_d = mode_q;
                endcase
            end
            default: if (timeout) mode_d = MODE_OFF;
        endcase
    end

    // Mode register and registered press pulse, updated on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q        <= MODE_OFF;
            press_event_q <= 3'b000;
        end else begin
            mode_q        <= mode_d;
            press_event_q <= accept;
        end
    end

    // LED driver. Any mode change restarts the blink timer and lights the LED unless the new mode is OFF.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_q     <= 1'b0;
            blink_cnt <= '0;
        end else if (mode_d != mode_q) begin
            led_q     <= (mode_d != MODE_OFF);
            blink_cnt <= '0;
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    led_q     <= 1'b0;
                    blink_cnt <= '0;
                end
                MODE_ON: begin
                    led_q     <= 1'b1;
                    blink_cnt <= '0;
                end
                MODE_SLOW: begin
                    if (blink_cnt == SLOW_LAST) begin
                        led_q     <= ~led_q;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
                default: begin
                    if (blink_cnt == FAST_LAST) begin
                        led_q     <= ~led_q;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.led         = led_q;
    assign bus.mode        = mode_q;
    assign bus.press_event = press_event_q;

endmodule
